mul_bf16_pipe: RTL and testbench

- Three-stage pipelined BF16 multiplier with valid/ready handshake on both sides.
- Sits directly upstream of the systolic-array BF16 adder in each PE and produces the a*b product that the adder accumulates.
- Subnormal inputs and results are flushed to zero. Rounding is round-to-nearest, ties-to-even.
- Per-product flags travel alongside the result: overflow, underflow, invalid.

---
 rtl/mul_bf16_pipe.sv | 165 ++++++++++++++++
 tb/tb_mul_bf16_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_bf16_pipe.sv
// mul_bf16_pipe: three-stage BF16 multiplier, flush-to-zero, RNE rounding.
// Each stage has its own valid bit; the ready chain is combinational, with no skid buffer.
module mul_bf16_pipe #(
  parameter logic [15:0] CANON_NAN = 16'h7FC0
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod_out,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  typedef enum logic [1:0] {
    CL_NORM,
    CL_ZERO,
    CL_INF,
    CL_NAN
  } cls_e;

  typedef struct packed {
    logic       sign;
    cls_e       cls;
    logic [7:0] ma;
    logic [7:0] mb;
    logic [9:0] esum;
  } s1_t;

  typedef struct packed {
    logic        sign;
    cls_e        cls;
    logic [15:0] p;
    logic [9:0]  esum;
  } s2_t;

  logic v1, v2, v3;
  logic en1, en2, en3;
  s1_t  s1, s1_d;
  s2_t  s2, s2_d;

  assign en3       = !v3 | out_ready;
  assign en2       = !v2 | en3;
  assign en1       = !v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  assign a_zero = a_in[14:7] == 8'h00;
  assign b_zero = b_in[14:7] == 8'h00;
  assign a_inf  = a_in[14:7] == 8'hFF && a_in[6:0] == 7'h0;
  assign b_inf  = b_in[14:7] == 8'hFF && b_in[6:0] == 7'h0;
  assign a_nan  = a_in[14:7] == 8'hFF && a_in[6:0] != 7'h0;
  assign b_nan  = b_in[14:7] == 8'hFF && b_in[6:0] != 7'h0;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = a_in[15] ^ b_in[15];
    s1_d.ma   = {1'b1, a_in[6:0]};
    s1_d.mb   = {1'b1, b_in[6:0]};
    s1_d.esum = {2'b00, a_in[14:7]}
              + {2'b00, b_in[14:7]}
              - 10'd127;
    // inf*0 is invalid and must win over the plain inf class
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf))
      s1_d.cls = CL_NAN;
    else if (a_inf | b_inf)
      s1_d.cls = CL_INF;
    else if (a_zero | b_zero)
      s1_d.cls = CL_ZERO;
    else
      s1_d.cls = CL_NORM;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      s1 <= s1_d;
    end
  end

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1.sign;
    s2_d.cls  = s1.cls;
    s2_d.p    = {8'h00, s1.ma} * {8'h00, s1.mb};
    s2_d.esum = s1.esum;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      s2 <= s2_d;
    end
  end

  logic              hi, g, st, rnd;
  logic [6:0]        frac;
  logic [7:0]        fr;
  logic signed [9:0] e;
  logic [15:0]       y;
  logic              ov, un, nv;

  always_comb begin
    hi   = s2.p[15];
    frac = hi ? s2.p[14:8] : s2.p[13:7];
    g    = hi ? s2.p[7] : s2.p[6];
    st   = hi ? |s2.p[6:0] : |s2.p[5:0];
    rnd  = g & (st | frac[0]);
    fr   = {1'b0, frac} + {7'd0, rnd};
    // a rounding carry leaves fr[6:0] at zero and bumps the exponent
    e    = s2.esum + {9'd0, hi} + {9'd0, fr[7]};
    y    = {s2.sign, e[7:0], fr[6:0]};
    ov   = 1'b0;
    un   = 1'b0;
    nv   = 1'b0;
    unique case (s2.cls)
      CL_NAN: begin
        y  = CANON_NAN;
        nv = 1'b1;
      end
      CL_INF:  y = {s2.sign, 8'hFF, 7'h0};
      CL_ZERO: y = {s2.sign, 15'h0};
      default: begin
        if (e >= 10'sd255) begin
          y  = {s2.sign, 8'hFF, 7'h0};
          ov = 1'b1;
        end else if (e <= 10'sd0) begin
          y  = {s2.sign, 15'h0};
          un = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      v3        <= 1'b0;
      prod_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (en3) begin
      v3        <= v2;
      prod_out  <= y;
      overflow  <= ov & v2;
      underflow <= un & v2;
      invalid   <= nv & v2;
    end
  end

endmodule

// File: tb/tb_mul_bf16_pipe.sv
// tb_mul_bf16_pipe: directed vectors, arithmetic reference model,
// in-order scoreboard, hold/backpressure and reset checks.
module tb_mul_bf16_pipe;

  logic        clk;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod_out;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  mul_bf16_pipe dut (
    .clk       (clk),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_out  (prod_out),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [18:0] act,
                     input logic [18:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result = {prod[15:0], overflow, underflow, invalid}
  function automatic logic [18:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    int ea, eb, fa, fb, m, k, q, rem, half, e;
    bit s, za, zb, ia, ib, na, nb;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    fa = int'(a[6:0]);
    fb = int'(b[6:0]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    if (na || nb || (ia && zb) || (za && ib))
      return {16'h7FC0, 3'b001};
    if (ia || ib)
      return {s, 8'hFF, 7'h0, 3'b000};
    if (za || zb)
      return {s, 15'h0, 3'b000};
    // exact product is m * 2^(ea+eb-254-14); keep 8 significant bits
    m = (128 + fa) * (128 + fb);
    e = ea + eb - 127;
    k = 7;
    if (m >= 32768) begin
      k = 8;
      e++;
    end
    q    = m >> k;
    rem  = m - (q << k);
    half = 1 << (k - 1);
    if (rem > half || (rem == half && (q % 2) == 1))
      q++;
    if (q == 256) begin
      q = 128;
      e++;
    end
    if (e >= 255)
      return {s, 8'hFF, 7'h0, 3'b100};
    if (e <= 0)
      return {s, 15'h0, 3'b010};
    return {s, e[7:0], q[6:0], 3'b000};
  endfunction

  localparam int ND = 19;

  logic [15:0] dv_a [ND] = '{
    16'h3F80, 16'h3FC0, 16'h3FC0, 16'h3F81,
    16'h7F00, 16'h0080, 16'hBF80, 16'h7F80,
    16'h7FC1, 16'hFF80, 16'h0001, 16'hC000,
    16'h7F80, 16'h0000, 16'h0080, 16'h7F7F,
    16'h7F7F, 16'h0080, 16'h8000
  };
  logic [15:0] dv_b [ND] = '{
    16'h4000, 16'h3FC0, 16'h3F81, 16'h3F81,
    16'h4000, 16'h0080, 16'h3F80, 16'h0000,
    16'h3F80, 16'h4000, 16'h4000, 16'hC040,
    16'hC000, 16'hFF80, 16'h3F80, 16'h3F80,
    16'h3F81, 16'h3F00, 16'h3F80
  };
  logic [18:0] dv_e [ND] = '{
    {16'h4000, 3'b000}, {16'h4010, 3'b000},
    {16'h3FC2, 3'b000}, {16'h3F82, 3'b000},
    {16'h7F80, 3'b100}, {16'h0000, 3'b010},
    {16'hBF80, 3'b000}, {16'h7FC0, 3'b001},
    {16'h7FC0, 3'b001}, {16'hFF80, 3'b000},
    {16'h0000, 3'b000}, {16'h40C0, 3'b000},
    {16'hFF80, 3'b000}, {16'h7FC0, 3'b001},
    {16'h0080, 3'b000}, {16'h7F7F, 3'b000},
    {16'h7F80, 3'b100}, {16'h0000, 3'b010},
    {16'h8000, 3'b000}
  };

  logic [15:0] bp_a [6] = '{
    16'h3F80, 16'h4000, 16'h4040,
    16'h3F80, 16'h4080, 16'h3FC0
  };
  logic [15:0] bp_b [6] = '{
    16'h3F80, 16'h4000, 16'h3F80,
    16'hC000, 16'h4000, 16'h4040
  };

  logic [18:0] exp_q [$];
  logic        hold_chk;
  logic [18:0] hold_val;
  logic [18:0] e_tmp;
  logic [18:0] got;

  assign got = {prod_out, overflow, underflow, invalid};

  // Scoreboard: everything sampled mid-cycle, inputs are stable here
  always @(negedge clk) begin
    if (!nRST) begin
      exp_q.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk)
        chk("hold_stable", got, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 19'(out_valid), 19'd0);
        end else begin
          e_tmp = exp_q.pop_front();
          chk("result", got, e_tmp);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(a_in, b_in));
      hold_chk = out_valid && !out_ready;
      hold_val = got;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int c;
    c        = 0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(negedge clk);
    while (!in_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("send_ready", 19'(in_ready), 19'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", 19'(exp_q.size()), 19'd0);
  endtask

  int idx;

  initial begin
    nRST      = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 19'(out_valid), 19'd0);
    chk("rst_outputs", got, 19'd0);
    chk("rst_in_ready", 19'(in_ready), 19'd1);

    for (int i = 0; i < ND; i++)
      chk($sformatf("model_pin_%0d", i),
          model(dv_a[i], dv_b[i]), dv_e[i]);

    #10 nRST = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at next edge, visible after three edges
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = dv_a[0];
    b_in      = dv_b[0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        chk("lat_early", 19'(out_valid), 19'd0);
      end else begin
        chk("lat_valid", 19'(out_valid), 19'd1);
        chk("lat_prod", 19'(prod_out), 19'h4000);
      end
    end
    @(posedge clk);
    #1;

    for (int i = 1; i < ND; i++)
      send(dv_a[i], dv_b[i]);
    drain();

    // Backpressure: six pairs offered, only three fit
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    a_in      = bp_a[0];
    b_in      = bp_b[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready)
        idx++;
      @(posedge clk);
      #1;
      if (idx < 6) begin
        a_in = bp_a[idx];
        b_in = bp_b[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("bp_accepted", 19'(idx), 19'd3);
    chk("bp_in_ready", 19'(in_ready), 19'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_no_gap", 19'(out_valid), 19'd1);
      if (in_valid && in_ready)
        idx++;
      @(posedge clk);
      #1;
      if (idx < 6) begin
        a_in = bp_a[idx];
        b_in = bp_b[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("bp_all_sent", 19'(idx), 19'd6);
    drain();

    // Reset with three products in flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(dv_a[i + 1], dv_b[i + 1]);
    chk("pre_rst_full", 19'(in_ready), 19'd0);
    chk("pre_rst_valid", 19'(out_valid), 19'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_rst_valid", 19'(out_valid), 19'd0);
    chk("async_rst_out", got, 19'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    nRST      = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_idle", 19'(out_valid), 19'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
